// File: rtl/vga_alarm_pkg.sv
// Shared timing constants, colour words, alarm codes and FSM states for the VGA alarm decoder.
package vga_alarm_pkg;

   localparam int H_SYNC        = 96;
   localparam int H_BP          = 48;
   localparam int V_SYNC        = 2;
   localparam int V_BP          = 33;
   localparam int H_TOTAL       = 800;
   localparam int V_TOTAL       = 525;
   localparam int SAMPLE_H      = H_SYNC + H_BP + 320;
   localparam int SAMPLE_V      = V_SYNC + V_BP + 240;
   localparam int LOCK_FRAMES   = 2;
   localparam int STABLE_FRAMES = 3;

   // Colour words are {R1R0, G1G0, B1B0}
   localparam logic [5:0] COL_BLACK   = 6'b000000;
   localparam logic [5:0] COL_WHITE   = 6'b111111;
   localparam logic [5:0] COL_YELLOW  = 6'b111100;
   localparam logic [5:0] COL_MAGENTA = 6'b110011;

   typedef enum logic [2:0] {
      ALM_IDLE      = 3'd0,
      ALM_TEMP      = 3'd1,
      ALM_WINDOW    = 3'd2,
      ALM_INTRUSION = 3'd3,
      ALM_UNKNOWN   = 3'd4
   } alarm_code_e;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } sync_state_e;

   function automatic alarm_code_e decode_colour(input logic [5:0] word);
      case (word)
         COL_WHITE:   return ALM_TEMP;
         COL_YELLOW:  return ALM_WINDOW;
         COL_MAGENTA: return ALM_INTRUSION;
         COL_BLACK:   return ALM_IDLE;
         default:     return ALM_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/vga_alarm_decoder_if.sv
// VGA input bus plus decoded alarm status; lost_cnt exists only with LOCK_LOSS_CNT_EN.
interface vga_alarm_decoder_if;
   import vga_alarm_pkg::*;

   logic [7:0]  vga_in;
   logic        locked;
   logic        alarm_valid;
   alarm_code_e alarm_code;
   logic        code_change;

`ifdef LOCK_LOSS_CNT_EN
   logic [7:0]  lost_cnt;

   modport master (output vga_in, input locked, alarm_valid, alarm_code, code_change, lost_cnt);
   modport slave  (input vga_in, output locked, alarm_valid, alarm_code, code_change, lost_cnt);
`else
   modport master (output vga_in, input locked, alarm_valid, alarm_code, code_change);
   modport slave  (input vga_in, output locked, alarm_valid, alarm_code, code_change);
`endif

endinterface

// File: rtl/vga_sync_tracker.sv
// Registers the VGA bus, measures line/frame timing against the expected totals and runs the lock FSM.
module vga_sync_tracker
   import vga_alarm_pkg::*;
#(
   parameter int H_TOTAL     = vga_alarm_pkg::H_TOTAL,
   parameter int V_TOTAL     = vga_alarm_pkg::V_TOTAL,
   parameter int SAMPLE_H    = vga_alarm_pkg::SAMPLE_H,
   parameter int SAMPLE_V    = vga_alarm_pkg::SAMPLE_V,
   parameter int LOCK_FRAMES = vga_alarm_pkg::LOCK_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] vga_i,
   output logic       locked_o,
   output logic       sample_strobe_o,
   output logic       lock_lost_o,
   output logic [5:0] sample_word_o
);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] SMP_H   = 10'(SAMPLE_H);
   localparam logic [9:0] SMP_V   = 10'(SAMPLE_V);
   localparam logic [1:0] LOCK_N  = 2'(LOCK_FRAMES);
   localparam logic [9:0] CNT_MAX = 10'h3FF;

   logic [1:0]  sync_q, sync_prev_q;
   logic [5:0]  pix_q;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        bad_line_q, bad_line_d;
   logic [1:0]  good_q, good_d;
   sync_state_e state_q, state_d;
   logic        hs_fall, vs_fall, line_bad, frame_good, lose;

   // Stage 0: input register; syncs reset to their idle level so no false edge follows reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         sync_prev_q <= 2'b11;
      end else begin
         sync_q      <= {vga_i[7], vga_i[3]};
         sync_prev_q <= sync_q;
      end
   end

   always_ff @(posedge clk) pix_q <= {vga_i[0], vga_i[4], vga_i[1], vga_i[5], vga_i[2], vga_i[6]};

   assign hs_fall    = sync_prev_q[1] & ~sync_q[1];
   assign vs_fall    = sync_prev_q[0] & ~sync_q[0];
   assign line_bad   = hs_fall && (hcnt_q != H_LAST);
   assign frame_good = (vcnt_q == V_LAST) && !bad_line_q && !line_bad;
   assign lose       = (state_q == LOCKED) &&
                       (line_bad || (vs_fall && !frame_good) || hcnt_q == CNT_MAX || vcnt_q == CNT_MAX);

   always_comb begin
      hcnt_d     = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
      vcnt_d     = vcnt_q;
      bad_line_d = bad_line_q | line_bad;
      if (hs_fall) begin
         hcnt_d = '0;
         if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
      end
      // vsync wins over a coincident hsync so each frame starts counting from zero
      if (vs_fall) begin
         vcnt_d     = '0;
         bad_line_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         SEARCH: if (vs_fall) begin
            state_d = TRACK;
            good_d  = '0;
         end
         TRACK: if (vs_fall) begin
            if (!frame_good)                good_d = '0;
            else if (good_q + 2'd1 == LOCK_N) begin
               state_d = LOCKED;
               good_d  = '0;
            end else                        good_d = good_q + 2'd1;
         end
         LOCKED: if (lose) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase
   end

   // Stage 1: counters and lock state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         bad_line_q <= 1'b0;
         good_q     <= '0;
         state_q    <= SEARCH;
      end else begin
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         bad_line_q <= bad_line_d;
         good_q     <= good_d;
         state_q    <= state_d;
      end
   end

   assign locked_o        = (state_q == LOCKED);
   assign sample_strobe_o = (state_q == LOCKED) && (hcnt_q == SMP_H) && (vcnt_q == SMP_V) && !lose;
   assign lock_lost_o     = lose;
   assign sample_word_o   = pix_q;

endmodule

// File: rtl/vga_alarm_decoder.sv
// Decodes the centre-pixel colour of a locked VGA stream into a debounced alarm code.
// Optional LOCK_LOSS_CNT_EN adds a saturating count of lock losses on lost_cnt.
module vga_alarm_decoder
   import vga_alarm_pkg::*;
#(
   parameter int H_TOTAL       = vga_alarm_pkg::H_TOTAL,
   parameter int V_TOTAL       = vga_alarm_pkg::V_TOTAL,
   parameter int SAMPLE_H      = vga_alarm_pkg::SAMPLE_H,
   parameter int SAMPLE_V      = vga_alarm_pkg::SAMPLE_V,
   parameter int LOCK_FRAMES   = vga_alarm_pkg::LOCK_FRAMES,
   parameter int STABLE_FRAMES = vga_alarm_pkg::STABLE_FRAMES
) (
   input logic                clk,
   input logic                rst_n,
   vga_alarm_decoder_if.slave bus_if
);
   localparam logic [1:0] STABLE_N = 2'(STABLE_FRAMES);

   logic        locked, sample_strobe, lock_lost;
   logic [5:0]  sample_word;
   alarm_code_e dec, cand_code_q, cand_code_d, code_q, code_d;
   logic [1:0]  cand_cnt_q, cand_cnt_d;
   logic        valid_q, valid_d, change_q, change_d;

   vga_sync_tracker #(
      .H_TOTAL    (H_TOTAL),
      .V_TOTAL    (V_TOTAL),
      .SAMPLE_H   (SAMPLE_H),
      .SAMPLE_V   (SAMPLE_V),
      .LOCK_FRAMES(LOCK_FRAMES)
   ) u_tracker (
      .clk            (clk),
      .rst_n          (rst_n),
      .vga_i          (bus_if.vga_in),
      .locked_o       (locked),
      .sample_strobe_o(sample_strobe),
      .lock_lost_o    (lock_lost),
      .sample_word_o  (sample_word)
   );

   assign dec = decode_colour(sample_word);

   always_comb begin
      cand_code_d = cand_code_q;
      cand_cnt_d  = cand_cnt_q;
      valid_d     = valid_q;
      code_d      = code_q;
      change_d    = 1'b0;
      // Lock loss drops validity but deliberately keeps the last published code
      if (lock_lost) begin
         cand_code_d = ALM_IDLE;
         cand_cnt_d  = '0;
         valid_d     = 1'b0;
      end else if (sample_strobe) begin
         if (dec == cand_code_q) begin
            if (cand_cnt_q != 2'd3) cand_cnt_d = cand_cnt_q + 2'd1;
         end else begin
            cand_code_d = dec;
            cand_cnt_d  = 2'd1;
         end
         if (cand_cnt_d == STABLE_N) begin
            valid_d = 1'b1;
            if (cand_code_d != code_q) begin
               code_d   = cand_code_d;
               change_d = 1'b1;
            end
         end
      end
   end

   // Stage 2: debounce state and published status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_code_q <= ALM_IDLE;
         cand_cnt_q  <= '0;
         valid_q     <= 1'b0;
         code_q      <= ALM_IDLE;
         change_q    <= 1'b0;
      end else begin
         cand_code_q <= cand_code_d;
         cand_cnt_q  <= cand_cnt_d;
         valid_q     <= valid_d;
         code_q      <= code_d;
         change_q    <= change_d;
      end
   end

   assign bus_if.locked      = locked;
   assign bus_if.alarm_valid = valid_q;
   assign bus_if.alarm_code  = code_q;
   assign bus_if.code_change = change_q;

`ifdef LOCK_LOSS_CNT_EN
   logic [7:0] lost_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                lost_cnt_q <= '0;
      else if (lock_lost && lost_cnt_q != 8'hFF) lost_cnt_q <= lost_cnt_q + 8'd1;
   end

   assign bus_if.lost_cnt = lost_cnt_q;
`endif

endmodule

// File: tb/tb_vga_alarm_decoder.sv
// Bench for vga_alarm_decoder: drives a reduced-size VGA raster with random decoy pixels and
// compares lock/decode/debounce behaviour against a frame-level reference model.
module tb_vga_alarm_decoder;

   localparam int HT     = 40;
   localparam int VT     = 20;
   localparam int SH     = 23;
   localparam int SV     = 11;
   localparam int LOCK_N = 2;
   localparam int STABLE = 3;
   localparam int DIS_Y  = 5;
   localparam logic [7:0] BUS_IDLE = 8'h88;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model state
   int         vs_seen;
   logic [2:0] m_code;
   logic       m_valid;
   logic       exp_chg;
   int         m_lost;
   logic [2:0] hist[$];

   vga_alarm_decoder_if vif();

   vga_alarm_decoder #(
      .H_TOTAL (HT),
      .V_TOTAL (VT),
      .SAMPLE_H(SH),
      .SAMPLE_V(SV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_if(vif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_code(input logic [5:0] c);
      if (c == 6'b111111) return 3'd1;
      if (c == 6'b111100) return 3'd2;
      if (c == 6'b110011) return 3'd3;
      if (c == 6'b000000) return 3'd0;
      return 3'd4;
   endfunction

   function automatic logic [7:0] pack(input logic hs, input logic vs, input logic [5:0] c);
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   task automatic reset_checks();
      chk("rst_locked", 32'(vif.locked), 32'd0);
      chk("rst_valid",  32'(vif.alarm_valid), 32'd0);
      chk("rst_code",   32'(vif.alarm_code), 32'd0);
      chk("rst_change", 32'(vif.code_change), 32'd0);
`ifdef LOCK_LOSS_CNT_EN
      chk("rst_lost",   32'(vif.lost_cnt), 32'd0);
`endif
   endtask

   task automatic model_reset();
      vs_seen = 0;
      hist.delete();
      m_code  = 3'd0;
      m_valid = 1'b0;
      exp_chg = 1'b0;
      m_lost  = 0;
   endtask

   task automatic model_sample(input logic [5:0] col);
      logic same;
      hist.push_back(exp_code(col));
      if (hist.size() >= STABLE) begin
         same = 1'b1;
         for (int k = 1; k < STABLE; k++)
            if (hist[hist.size()-1-k] != hist[hist.size()-1]) same = 1'b0;
         if (same) begin
            m_valid = 1'b1;
            if (m_code != hist[hist.size()-1]) begin
               m_code  = hist[hist.size()-1];
               exp_chg = 1'b1;
            end
         end
      end
   endtask

   // One frame: vsync at line 0, hsync at x<4 of every line; only the sampled pixel carries col.
   // dis_y/dis_len stretch or shrink one line; rst_y aborts the frame with an asynchronous reset.
   task automatic send_frame(input logic [5:0] col, input int dis_y, input int dis_len, input int rst_y);
      int         len;
      logic       lk;
      logic [5:0] c;
      vs_seen++;
      for (int y = 0; y < VT; y++) begin
         len = (y == dis_y) ? dis_len : HT;
         for (int x = 0; x < len; x++) begin
            @(negedge clk);
            if (dis_y >= 0 && y == dis_y + 1) begin
               if (x == 1 && dis_len < HT) chk("loss_not_early", 32'(vif.locked), 32'd1);
               if (x == 2) begin
                  if (vs_seen >= LOCK_N + 1) m_lost++;
                  vs_seen = 0;
                  hist.delete();
                  m_valid = 1'b0;
                  chk("loss_locked", 32'(vif.locked), 32'd0);
                  chk("loss_valid",  32'(vif.alarm_valid), 32'd0);
                  chk("loss_code",   32'(vif.alarm_code), 32'(m_code));
`ifdef LOCK_LOSS_CNT_EN
                  chk("loss_cnt",    32'(vif.lost_cnt), 32'(m_lost));
`endif
               end
            end
            if (y == SV && x == SH + 2) begin
               lk = (vs_seen >= LOCK_N + 1);
               chk("locked", 32'(vif.locked), 32'(lk));
               chk("code_pre", 32'(vif.alarm_code), 32'(m_code));
               exp_chg = 1'b0;
               if (lk) model_sample(col);
            end
            if (y == SV && x == SH + 3) begin
               chk("code_post", 32'(vif.alarm_code), 32'(m_code));
               chk("valid", 32'(vif.alarm_valid), 32'(m_valid));
               chk("change", 32'(vif.code_change), 32'(exp_chg));
            end
            if (y == SV && x == SH + 4) chk("change_clear", 32'(vif.code_change), 32'd0);
            if (y == rst_y && x == 5) begin
               rst_n = 1'b0;
               vif.vga_in = BUS_IDLE;
               #1;
               reset_checks();
               model_reset();
               repeat (2) @(negedge clk);
               rst_n = 1'b1;
               return;
            end
            c = (x == SH + 1 && y == SV) ? col : 6'($urandom);
            vif.vga_in = pack(x >= 4, y >= 2, c);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      logic [5:0] pal[4];
      logic [5:0] col;
      int         k;
      int         reps;
      pal = '{6'b000000, 6'b111111, 6'b111100, 6'b110011};

      rst_n      = 1'b0;
      vif.vga_in = BUS_IDLE;
      model_reset();
      repeat (3) @(negedge clk);
      reset_checks();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      repeat (5) send_frame(6'b000000, -1, 0, -1);
      repeat (3) send_frame(6'b111111, -1, 0, -1);
      repeat (3) send_frame(6'b111100, -1, 0, -1);
      repeat (2) begin
         send_frame(6'b110011, -1, 0, -1);
         send_frame(6'b111100, -1, 0, -1);
      end
      repeat (3) send_frame(6'b110011, -1, 0, -1);
      repeat (3) send_frame(6'b101010, -1, 0, -1);

      send_frame(6'b101010, DIS_Y, HT - 1, -1);
      repeat (3) send_frame(6'b101010, -1, 0, -1);
      send_frame(6'b101010, DIS_Y, 1100, -1);
      repeat (3) send_frame(6'b101010, -1, 0, -1);
      send_frame(6'b000000, -1, 0, 8);

      for (int g = 0; g < 8; g++) begin
         k    = int'($urandom_range(0, 4));
         col  = (k < 4) ? pal[k] : 6'($urandom);
         reps = int'($urandom_range(1, 4));
         repeat (reps) send_frame(col, -1, 0, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
